// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TileLink-UL constants for the 2:1 arbiter slice.
//   - A/D channel field widths
//   - opcode constants
//   - arbiter FSM state enum
package tl_ul_pkg;
   localparam int TL_AW   = 32;  // address
   localparam int TL_DW   = 32;  // data
   localparam int TL_MW   = 4;   // byte mask
   localparam int TL_SZW  = 4;   // size
   localparam int TL_OPW  = 3;   // opcode
   localparam int TL_APW  = 3;   // A param
   localparam int TL_DPW  = 2;   // D param
   localparam int TL_CNTW = 4;   // outstanding counter

   localparam logic [2:0] OP_GET          = 3'd4;
   localparam logic [2:0] OP_PUT_FULL     = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL  = 3'd1;
   localparam logic [2:0] OP_ACK          = 3'd0;
   localparam logic [2:0] OP_ACK_DATA     = 3'd1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_e;
endpackage

// File: rtl/tl_ul_out_cnt.sv
// tl_ul_out_cnt: per-requester outstanding transaction counter.
// Ports:
//   clock, reset  - clock, async active-high reset
//   i_inc         - A fire from this requester
//   i_dec         - D fire to this requester
//   o_full        - count has reached MAX_OUT
//   o_uflow       - D fire while count is zero (protocol error pulse)
module tl_ul_out_cnt
   import tl_ul_pkg::*;
#(
   parameter int MAX_OUT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full,
   output logic o_uflow
);
   localparam logic [TL_CNTW-1:0] MAX = TL_CNTW'(MAX_OUT);

   logic [TL_CNTW-1:0] r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (i_inc && !i_dec)
         r_cnt <= r_cnt + 1'b1;
      else if (!i_inc && i_dec && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;  // stray D at zero leaves count pinned
   end

   assign o_full  = (r_cnt == MAX);
   assign o_uflow = i_dec && (r_cnt == '0);
endmodule

// File: rtl/tl_ul_arb_2to1.sv
// tl_ul_arb_2to1: two-master TL-UL arbiter onto one slave port.
// Round-robin A grant held until handshake, D routed by source MSB,
// per-requester outstanding limit of MAX_OUT.
// Ports:
//   clock, reset          - clock, async active-high reset
//   in{0,1}_a_*           - requester A channels
//   in{0,1}_d_*           - requester D channels
//   out_a_*               - downstream A (source = {grant idx, src})
//   out_d_*               - downstream D
//   err_o                 - sticky protocol error (underflow / valid drop)
//   perf_grant0/1, perf_stall - only with TL_ARB_PERF_CNT_EN defined
module tl_ul_arb_2to1
   import tl_ul_pkg::*;
#(
   parameter int SRC_W   = 2,
   parameter int MAX_OUT = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in0_a_valid,
   output logic               in0_a_ready,
   input  logic [2:0]         in0_a_opcode,
   input  logic [2:0]         in0_a_param,
   input  logic [3:0]         in0_a_size,
   input  logic [SRC_W-1:0]   in0_a_source,
   input  logic [31:0]        in0_a_address,
   input  logic [3:0]         in0_a_mask,
   input  logic [31:0]        in0_a_data,
   output logic               in0_d_valid,
   input  logic               in0_d_ready,
   output logic [2:0]         in0_d_opcode,
   output logic [1:0]         in0_d_param,
   output logic [3:0]         in0_d_size,
   output logic [SRC_W-1:0]   in0_d_source,
   output logic               in0_d_sink,
   output logic               in0_d_denied,
   output logic               in0_d_corrupt,
   output logic [31:0]        in0_d_data,
   input  logic               in1_a_valid,
   output logic               in1_a_ready,
   input  logic [2:0]         in1_a_opcode,
   input  logic [2:0]         in1_a_param,
   input  logic [3:0]         in1_a_size,
   input  logic [SRC_W-1:0]   in1_a_source,
   input  logic [31:0]        in1_a_address,
   input  logic [3:0]         in1_a_mask,
   input  logic [31:0]        in1_a_data,
   output logic               in1_d_valid,
   input  logic               in1_d_ready,
   output logic [2:0]         in1_d_opcode,
   output logic [1:0]         in1_d_param,
   output logic [3:0]         in1_d_size,
   output logic [SRC_W-1:0]   in1_d_source,
   output logic               in1_d_sink,
   output logic               in1_d_denied,
   output logic               in1_d_corrupt,
   output logic [31:0]        in1_d_data,
   output logic               out_a_valid,
   input  logic               out_a_ready,
   output logic [2:0]         out_a_opcode,
   output logic [2:0]         out_a_param,
   output logic [3:0]         out_a_size,
   output logic [SRC_W:0]     out_a_source,
   output logic [31:0]        out_a_address,
   output logic [3:0]         out_a_mask,
   output logic [31:0]        out_a_data,
   input  logic               out_d_valid,
   output logic               out_d_ready,
   input  logic [2:0]         out_d_opcode,
   input  logic [1:0]         out_d_param,
   input  logic [3:0]         out_d_size,
   input  logic [SRC_W:0]     out_d_source,
   input  logic               out_d_sink,
   input  logic               out_d_denied,
   input  logic [31:0]        out_d_data,
   input  logic               out_d_corrupt,
   output logic               err_o
`ifdef TL_ARB_PERF_CNT_EN
  ,output logic [31:0]        perf_grant0,
   output logic [31:0]        perf_grant1,
   output logic [31:0]        perf_stall
`endif
);
   arb_state_e r_state;
   logic       r_hold_idx, r_last, r_err;
   logic       w_full0, w_full1, w_uflow0, w_uflow1;
   logic       w_elig0, w_elig1, w_idx, w_av, w_gnt, w_a_fire;
   logic       w_d_sel, w_d_fire0, w_d_fire1;

   assign w_elig0 = in0_a_valid && !w_full0;
   assign w_elig1 = in1_a_valid && !w_full1;

   // HOLD pins the mux to the registered index; the shown valid then
   // tracks that requester only, so a dropped valid is visible downstream.
   always_comb begin
      w_idx = 1'b0;
      w_av  = 1'b0;
      w_gnt = 1'b0;
      if (r_state == HOLD) begin
         w_idx = r_hold_idx;
         w_av  = r_hold_idx ? in1_a_valid : in0_a_valid;
         w_gnt = 1'b1;
      end else begin
         w_idx = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
         w_av  = w_elig0 || w_elig1;
         w_gnt = w_av;
      end
   end

   assign out_a_valid = w_av && !reset;
   assign w_a_fire    = out_a_valid && out_a_ready;
   assign in0_a_ready = out_a_ready && w_gnt && !reset && !w_idx;
   assign in1_a_ready = out_a_ready && w_gnt && !reset &&  w_idx;

   assign out_a_opcode  = w_idx ? in1_a_opcode  : in0_a_opcode;
   assign out_a_param   = w_idx ? in1_a_param   : in0_a_param;
   assign out_a_size    = w_idx ? in1_a_size    : in0_a_size;
   assign out_a_source  = {w_idx, (w_idx ? in1_a_source : in0_a_source)};
   assign out_a_address = w_idx ? in1_a_address : in0_a_address;
   assign out_a_mask    = w_idx ? in1_a_mask    : in0_a_mask;
   assign out_a_data    = w_idx ? in1_a_data    : in0_a_data;

   // D routing: source MSB names the requester that issued the A.
   assign w_d_sel     = out_d_source[SRC_W];
   assign in0_d_valid = out_d_valid && !w_d_sel;
   assign in1_d_valid = out_d_valid &&  w_d_sel;
   assign out_d_ready = w_d_sel ? in1_d_ready : in0_d_ready;
   assign w_d_fire0   = in0_d_valid && in0_d_ready;
   assign w_d_fire1   = in1_d_valid && in1_d_ready;

   assign in0_d_opcode  = out_d_opcode;   assign in1_d_opcode  = out_d_opcode;
   assign in0_d_param   = out_d_param;    assign in1_d_param   = out_d_param;
   assign in0_d_size    = out_d_size;     assign in1_d_size    = out_d_size;
   assign in0_d_source  = out_d_source[SRC_W-1:0];
   assign in1_d_source  = out_d_source[SRC_W-1:0];
   assign in0_d_sink    = out_d_sink;     assign in1_d_sink    = out_d_sink;
   assign in0_d_denied  = out_d_denied;   assign in1_d_denied  = out_d_denied;
   assign in0_d_corrupt = out_d_corrupt;  assign in1_d_corrupt = out_d_corrupt;
   assign in0_d_data    = out_d_data;     assign in1_d_data    = out_d_data;

   tl_ul_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
      .clock(clock), .reset(reset),
      .i_inc(w_a_fire && !w_idx), .i_dec(w_d_fire0),
      .o_full(w_full0), .o_uflow(w_uflow0));

   tl_ul_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
      .clock(clock), .reset(reset),
      .i_inc(w_a_fire && w_idx), .i_dec(w_d_fire1),
      .o_full(w_full1), .o_uflow(w_uflow1));

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_hold_idx <= 1'b0;
         r_last     <= 1'b1;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_av && !out_a_ready) begin
                     r_state    <= HOLD;
                     r_hold_idx <= w_idx;
                  end
            HOLD: if (w_a_fire) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_a_fire) r_last <= w_idx;
         if (w_uflow0 || w_uflow1 || (r_state == HOLD && !w_av))
            r_err <= 1'b1;
      end
   end

   assign err_o = r_err;

`ifdef TL_ARB_PERF_CNT_EN
   logic [31:0] r_pg0, r_pg1, r_pst;
   logic        w_stall;

   assign w_stall = (in0_a_valid && w_full0) || (in1_a_valid && w_full1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pg0 <= '0;
         r_pg1 <= '0;
         r_pst <= '0;
      end else begin
         if (w_a_fire && !w_idx) r_pg0 <= r_pg0 + 1'b1;
         if (w_a_fire &&  w_idx) r_pg1 <= r_pg1 + 1'b1;
         if (w_stall)            r_pst <= r_pst + 1'b1;
      end
   end

   assign perf_grant0 = r_pg0;
   assign perf_grant1 = r_pg1;
   assign perf_stall  = r_pst;
`endif
endmodule

// File: tb/tb_tl_ul_arb_2to1.sv
module tb_tl_ul_arb_2to1;
  import tl_ul_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0] in0_a_opcode, in0_a_param, in1_a_opcode, in1_a_param;
  logic [3:0] in0_a_size, in0_a_mask, in1_a_size, in1_a_mask;
  logic [1:0] in0_a_source, in1_a_source;
  logic [31:0] in0_a_address, in0_a_data, in1_a_address, in1_a_data;
  logic in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
  logic [2:0] in0_d_opcode, in1_d_opcode;
  logic [1:0] in0_d_param, in1_d_param, in0_d_source, in1_d_source;
  logic [3:0] in0_d_size, in1_d_size;
  logic in0_d_sink, in0_d_denied, in0_d_corrupt, in1_d_sink, in1_d_denied, in1_d_corrupt;
  logic [31:0] in0_d_data, in1_d_data;
  logic out_a_valid, out_a_ready;
  logic [2:0] out_a_opcode, out_a_param;
  logic [3:0] out_a_size, out_a_mask;
  logic [2:0] out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic out_d_valid, out_d_ready;
  logic [2:0] out_d_opcode;
  logic [1:0] out_d_param;
  logic [3:0] out_d_size;
  logic [2:0] out_d_source;
  logic out_d_sink, out_d_denied, out_d_corrupt;
  logic [31:0] out_d_data;
  logic err_o;
`ifdef TL_ARB_PERF_CNT_EN
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

  tl_ul_arb_2to1 #(.SRC_W(2), .MAX_OUT(4)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
    .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_param(in0_d_param), .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
    .in0_d_sink(in0_d_sink), .in0_d_denied(in0_d_denied), .in0_d_corrupt(in0_d_corrupt),
    .in0_d_data(in0_d_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
    .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_param(in1_d_param), .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
    .in1_d_sink(in1_d_sink), .in1_d_denied(in1_d_denied), .in1_d_corrupt(in1_d_corrupt),
    .in1_d_data(in1_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
    .out_d_corrupt(out_d_corrupt), .err_o(err_o)
`ifdef TL_ARB_PERF_CNT_EN
   ,.perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // one cycle: inputs | expected combinational outputs and err_o
  typedef struct {
    logic v0, v1, ardy, dv;
    logic [2:0] dsrc;
    logic dr0, dr1;
    logic e_av, e_msb, e_ar0, e_ar1, e_dv0, e_dv1, e_dr, e_err;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    in0_a_valid = r.v0; in1_a_valid = r.v1; out_a_ready = r.ardy;
    out_d_valid = r.dv; out_d_source = r.dsrc;
    in0_d_ready = r.dr0; in1_d_ready = r.dr1;
  endtask

  task automatic set_a(input logic v0, input logic v1, input logic ardy);
    in0_a_valid = v0; in1_a_valid = v1; out_a_ready = ardy;
    out_d_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    in0_a_opcode = OP_GET; in0_a_param = 3'd0; in0_a_size = 4'd2; in0_a_source = 2'b01;
    in0_a_address = 32'h1000_0040; in0_a_mask = 4'hF; in0_a_data = 32'hAAAA_0000;
    in1_a_opcode = OP_PUT_FULL; in1_a_param = 3'd0; in1_a_size = 4'd2; in1_a_source = 2'b10;
    in1_a_address = 32'h2000_0080; in1_a_mask = 4'hF; in1_a_data = 32'hBBBB_1111;
    out_d_opcode = OP_ACK_DATA; out_d_param = 2'd0; out_d_size = 4'd2; out_d_sink = 1'b0;
    out_d_denied = 1'b0; out_d_corrupt = 1'b0; out_d_data = 32'h5A5A_A5A5;
    in0_d_ready = 1'b1; in1_d_ready = 1'b1; out_d_source = 3'd0;
    set_a(1'b1, 1'b1, 1'b1);

    //            v0 v1 ar dv dsrc d0 d1 | av msb ar0 ar1 dv0 dv1 dr err
    // round robin with D returned the following cycle
    tbl.push_back('{1,1,1,0,3'd0,1,1, 1,0,1,0,0,0,1,0});
    tbl.push_back('{1,1,1,1,3'd0,1,1, 1,1,0,1,1,0,1,0});
    tbl.push_back('{1,1,1,1,3'd4,1,1, 1,0,1,0,0,1,1,0});
    tbl.push_back('{1,1,1,1,3'd0,1,1, 1,1,0,1,1,0,1,0});
    tbl.push_back('{1,0,1,1,3'd4,1,1, 1,0,1,0,0,1,1,0});
    tbl.push_back('{0,0,1,1,3'd0,1,1, 0,0,0,0,1,0,1,0});
    // held grant: last=0, req1 arrives mid-hold but req0 keeps the bus
    tbl.push_back('{1,0,0,0,3'd0,1,1, 1,0,0,0,0,0,1,0});
    tbl.push_back('{1,1,0,0,3'd0,1,1, 1,0,0,0,0,0,1,0});
    tbl.push_back('{1,1,0,0,3'd0,1,1, 1,0,0,0,0,0,1,0});
    tbl.push_back('{1,1,1,0,3'd0,1,1, 1,0,1,0,0,0,1,0});
    tbl.push_back('{1,1,1,0,3'd0,1,1, 1,1,0,1,0,0,1,0});
    tbl.push_back('{0,0,0,1,3'd0,1,1, 0,0,0,0,1,0,1,0});
    tbl.push_back('{0,0,0,1,3'd4,1,1, 0,0,0,0,0,1,1,0});
    // four outstanding on req0, fifth blocked until a D returns
    for (int i = 0; i < 4; i++) tbl.push_back('{1,0,1,0,3'd0,1,1, 1,0,1,0,0,0,1,0});
    tbl.push_back('{1,0,1,0,3'd0,1,1, 0,0,0,0,0,0,1,0});
    tbl.push_back('{1,0,1,1,3'd0,1,1, 0,0,0,0,1,0,1,0});
    tbl.push_back('{1,0,1,0,3'd0,1,1, 1,0,1,0,0,0,1,0});
    for (int i = 0; i < 4; i++) tbl.push_back('{0,0,1,1,3'd0,1,1, 0,0,0,0,1,0,1,0});
    // req1: cnt 2, simultaneous A+D keeps 2, two more fill to 4
    tbl.push_back('{0,1,1,0,3'd0,1,1, 1,1,0,1,0,0,1,0});
    tbl.push_back('{0,1,1,0,3'd0,1,1, 1,1,0,1,0,0,1,0});
    tbl.push_back('{0,1,1,1,3'd4,1,1, 1,1,0,1,0,1,1,0});
    tbl.push_back('{0,1,1,0,3'd0,1,1, 1,1,0,1,0,0,1,0});
    tbl.push_back('{0,1,1,0,3'd0,1,1, 1,1,0,1,0,0,1,0});
    tbl.push_back('{0,1,1,0,3'd0,1,1, 0,0,0,0,0,0,1,0});
    // D backpressured by req1, then drain to zero
    tbl.push_back('{0,0,1,1,3'd4,1,0, 0,0,0,0,0,1,0,0});
    for (int i = 0; i < 4; i++) tbl.push_back('{0,0,1,1,3'd4,1,1, 0,0,0,0,0,1,1,0});
    // stray D to req1 at cnt 0: routed, err sticky from next cycle
    tbl.push_back('{0,0,1,1,3'd6,1,1, 0,0,0,0,0,1,1,0});
    tbl.push_back('{0,0,0,0,3'd0,1,1, 0,0,0,0,0,0,1,1});
    tbl.push_back('{0,0,0,0,3'd0,1,1, 0,0,0,0,0,0,1,1});

    // reset state: out_a_valid suppressed even with requesters valid
    #2;
    chk("rst_out_a_valid", 32'(out_a_valid), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_a_ready0", 32'(in0_a_ready), 32'd0);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #4;
      chk($sformatf("v%0d_out_a_valid", i), 32'(out_a_valid), 32'(tbl[i].e_av));
      if (tbl[i].e_av) begin
        chk($sformatf("v%0d_out_a_source", i), 32'(out_a_source),
            32'({tbl[i].e_msb, (tbl[i].e_msb ? 2'b10 : 2'b01)}));
        chk($sformatf("v%0d_out_a_address", i), out_a_address,
            tbl[i].e_msb ? 32'h2000_0080 : 32'h1000_0040);
      end
      chk($sformatf("v%0d_a_ready0", i), 32'(in0_a_ready), 32'(tbl[i].e_ar0));
      chk($sformatf("v%0d_a_ready1", i), 32'(in1_a_ready), 32'(tbl[i].e_ar1));
      chk($sformatf("v%0d_d_valid0", i), 32'(in0_d_valid), 32'(tbl[i].e_dv0));
      chk($sformatf("v%0d_d_valid1", i), 32'(in1_d_valid), 32'(tbl[i].e_dv1));
      chk($sformatf("v%0d_out_d_ready", i), 32'(out_d_ready), 32'(tbl[i].e_dr));
      if (tbl[i].dv) begin
        chk($sformatf("v%0d_d_source1", i), 32'(in1_d_source), 32'(tbl[i].dsrc[1:0]));
        chk($sformatf("v%0d_d_data0", i), in0_d_data, 32'h5A5A_A5A5);
      end
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].e_err));
      @(posedge clock);
      #1;
    end

`ifdef TL_ARB_PERF_CNT_EN
    chk("perf_grant0_run", perf_grant0, 32'd9);
    chk("perf_grant1_run", perf_grant1, 32'd8);
    chk("perf_stall_run", perf_stall, 32'd3);
`endif

    // reset while holding: last grant was 0, so without reset a tie would go to 1
    set_a(1'b1, 1'b0, 1'b1);
    next_cycle();
    set_a(1'b1, 1'b0, 1'b0);
    next_cycle();
    chk("hold_out_a_valid", 32'(out_a_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("hold_rst_out_a_valid", 32'(out_a_valid), 32'd0);
    chk("hold_rst_err", 32'(err_o), 32'd0);
    next_cycle();
    reset = 1'b0;
`ifdef TL_ARB_PERF_CNT_EN
    chk("perf_grant0_rst", perf_grant0, 32'd0);
    chk("perf_grant1_rst", perf_grant1, 32'd0);
    chk("perf_stall_rst", perf_stall, 32'd0);
`endif
    set_a(1'b1, 1'b1, 1'b1);
    #1;
    chk("post_rst_tie_src", 32'(out_a_source), 32'h1);
    chk("post_rst_a_ready0", 32'(in0_a_ready), 32'd1);
    next_cycle();

    // requester drops valid while held: stays on it, err raised
    set_a(1'b1, 1'b0, 1'b0);
    next_cycle();
    set_a(1'b0, 1'b1, 1'b0);
    #1;
    chk("drop_out_a_valid", 32'(out_a_valid), 32'd0);
    chk("drop_out_a_src_msb", 32'(out_a_source[2]), 32'd0);
    next_cycle();
    chk("drop_err", 32'(err_o), 32'd1);
    out_a_ready = 1'b1;
    #1;
    chk("drop_still_held", 32'(in1_a_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/tl_ul_arb_2to1.md
Name: tl_ul_arb_2to1

Overview:
- Two-requester TileLink-UL arbiter that shares one 32-bit TL-UL slave port (A/D channel bundle) between two masters, e.g. core data port and debug/DMA port, ahead of the peripheral crossbar.
- Round-robin grant on the A channel, with the grant held until handshake.
- Source-ID tagging routes D responses back to the issuing requester.
- Per-requester outstanding-transaction limiting.

Parameters:
- SRC_W, 2, requester-side source ID width; downstream source width is SRC_W+1.
- MAX_OUT, 4, maximum outstanding (A fired, D not yet fired) transactions per requester; range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in{0,1}_a_valid / in{0,1}_a_ready  in / out  1  requester A handshake.
- in{0,1}_a_opcode  in  3  requester A opcode.
- in{0,1}_a_param  in  3  requester A param.
- in{0,1}_a_size  in  4  requester A size.
- in{0,1}_a_source  in  SRC_W  requester A source ID.
- in{0,1}_a_address  in  32  requester A address.
- in{0,1}_a_mask  in  4  requester A byte mask.
- in{0,1}_a_data  in  32  requester A data.
- in{0,1}_d_valid / in{0,1}_d_ready  out / in  1  requester D handshake.
- in{0,1}_d_opcode  out  3  D opcode to requester.
- in{0,1}_d_param  out  2  D param to requester.
- in{0,1}_d_size  out  4  D size to requester.
- in{0,1}_d_source  out  SRC_W  D source ID to requester.
- in{0,1}_d_sink, in{0,1}_d_denied, in{0,1}_d_corrupt  out  1  D sideband to requester.
- in{0,1}_d_data  out  32  D data to requester.
- out_a_valid / out_a_ready  out / in  1  downstream A handshake.
- out_a_opcode, out_a_param, out_a_size, out_a_address, out_a_mask, out_a_data  out  3/3/4/32/4/32  selected A fields.
- out_a_source  out  SRC_W+1  {grant index, requester source}.
- out_d_valid / out_d_ready  in / out  1  downstream D handshake.
- out_d_opcode, out_d_param, out_d_size, out_d_sink, out_d_denied, out_d_data, out_d_corrupt  in  3/2/4/1/1/32/1  downstream D fields.
- out_d_source  in  SRC_W+1  downstream D source ID.
- err_o  out  1  sticky protocol error.

Behaviour:
- Eligibility: requester i is eligible when in{i}_a_valid is high and outstanding count cnt{i} < MAX_OUT.
- FSM states:
  - IDLE: combinational grant to an eligible requester. If both are eligible, pick the one not equal to last_grant. Set out_a_valid when any requester is eligible. Only the granted requester sees a_ready = out_a_ready.
  - On out_a_valid & !out_a_ready: go to HOLD and register the grant index. In HOLD the mux stays on that requester regardless of the other requester or cnt changes (TL valid-stability rule). HOLD exits to IDLE on out_a_ready.
  - On A fire, in either state: last_grant <= index.
- Zero-latency path: no A-path registers; the A fields are a mux only.
- Source mapping: out_a_source = {idx, in_a_source}.
- D routing by out_d_source[SRC_W]:
  - in{k}_d_valid = out_d_valid & (MSB==k).
  - out_d_ready = in{k}_d_ready of the selected k.
  - Other D fields go to both requesters. The lower SRC_W bits of source are passed through.
- Outstanding counter cnt{i}, width 4:
  - +1 on A fire from i; −1 on D fire to i; unchanged when both occur in the same cycle.
  - Saturates at MAX_OUT: the eligibility gate prevents a further A fire.
  - D fire to a requester with cnt==0 sets err_o and leaves cnt at 0. err_o is cleared only by reset.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), cnt0=cnt1=0, err_o=0.
- All handshake outputs are combinational from inputs and state; out_a_valid=0 while reset is asserted.
- Reset asserted mid-transaction (including in HOLD) immediately returns to IDLE and drops all counts. Downstream is expected to be reset together with this block.
- Requester dropping a_valid while held: this is a protocol violation. The FSM stays in HOLD (out_a_valid follows in_a_valid) and err_o is set.

Optional Feature:
- Macro TL_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_grant0 and perf_grant1 (32 bits each) and perf_stall (32 bits).
  - perf_grant{i} counts A fires per requester and wraps at 2^32.
  - perf_stall counts cycles where a requester has a_valid but is ineligible due to cnt==MAX_OUT.
  - All three reset to 0.
- When undefined: these ports and their logic are absent, with no other behavioural change.

Decomposition:
- Package tl_ul_pkg holds:
  - opcode constants: Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1;
  - field-width localparams;
  - the FSM state enum {IDLE, HOLD}.
- One sub-module, tl_ul_out_cnt, instanced twice: the outstanding counter with inc/dec/full/underflow-error outputs.

Test Plan:
- Both requesters valid every cycle, out_a_ready=1, D returned the next cycle → grants alternate 0,1,0,1; out_a_source MSB alternates; no err_o.
- Requester 0 valid with out_a_ready held low 3 cycles, requester 1 raises valid in cycle 2 → grant stays 0 until ready; requester 1 is granted the next cycle.
- MAX_OUT=4, requester 0 issues 4 Gets with no D returned → 5th A blocked (in0_a_ready=0, out_a_valid=0 if requester 1 idle); one D with source MSB 0 → 5th fires.
- Simultaneous A fire and D fire for requester 1 at cnt=2 → cnt stays 2.
- D with source {1, 2'b10} and cnt1=0 → in1_d_valid=1, in1_d_source=2'b10, err_o=1 sticky.
- Reset asserted while in HOLD → out_a_valid=0 immediately; after release, tie resolves to requester 0; with TL_ARB_PERF_CNT_EN defined, perf counters read 0.
